control_unit_fsm: RTL and testbench
===================================

// Module: control_unit_fsm
// PURPOSE
//  Multicycle controller for the RV64 datapath. Decodes IR fields; drives all datapath controls
//  (sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc, pc_next_sel, pc_adder_sel).
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction class. Instantiated beside datapath in the CPU top.
// PARAMETERS
//  RESET_CYCLES  1  cycles reset_pc is held high after RST_N release (>=1)
//  FUNCT7_CHECK  1  1: R-type with funct7 not in {0x00,0x20} is illegal; 0: funct7[5] only
// PORTS
//  CLK           in   1  clock, rising edge
//  RST_N         in   1  asynchronous, active-low reset
//  opcode        in   7  instruction[6:0]
//  funct3        in   3  instruction[14:12]
//  funct7        in   7  instruction[31:25]
//  sub, WE_RF, WE_MEM, ULA_din2_sel, load_pc, reset_pc, pc_next_sel, pc_adder_sel  out 1 each
//  RF_din_sel    out  2  00 DM_out, 01 ULA, 1x last_pc (link)
//  instr_done    out  1  1-cycle pulse in final state of each instruction
//  illegal       out  1  high while decoded class is ILLEGAL (DECODE onward)
// BEHAVIOUR
//  - One clock, async active-low reset: RST_N=0 forces S_RESET at once. Every output 0 except reset_pc=1.
//  - Outputs: combinational from state + registered class (Moore). Class is latched in DECODE.
//  - S_RESET: reset_pc=1 for RESET_CYCLES cycles after release -> S_FETCH.
//  - S_FETCH: all enables 0; IR captures IM[PC] at cycle end -> S_DECODE.
//  - S_DECODE: class from opcode: R 0110011, I 0010011, LOAD 0000011, STORE 0100011,
//    BRANCH 1100011, JAL 1101111, JALR 1100111, else ILLEGAL -> S_EXEC.
//  - ULA_din2_sel=1 from DECODE to WB for I/LOAD/STORE; else 0.
//  - sub=1: R with funct3=000 & funct7[5]=1, and all BRANCH.
//  - Per class, states after DECODE (cycle counts include FETCH/DECODE):
//    R/I:    EXEC -> WB: WE_RF=1, RF_din_sel=01, load_pc=1, pc_next_sel=0. 4 cycles.
//    LOAD:   EXEC -> MEM (addr = ula[4:0] stable) -> WB: WE_RF=1, RF_din_sel=00, load_pc=1. 5 cycles.
//    STORE:  EXEC -> MEM: WE_MEM=1, load_pc=1. 4 cycles; no WB.
//    BRANCH: EXEC: load_pc=1, pc_next_sel=1; PC unit resolves taken/not-taken from flags+funct3. 3 cycles.
//    JAL/JALR: EXEC: load_pc=1, pc_next_sel=1, pc_adder_sel=(JALR). last_pc captures return addr.
//              Then WB: WE_RF=1, RF_din_sel=10, load_pc=0. 4 cycles.
//  - Final state of every instruction asserts instr_done and returns to S_FETCH.
//  - load_pc is asserted in exactly one cycle per instruction. WE_RF and WE_MEM are never both high.
//  - Writes to rd=x0 are not suppressed here (regfile owns x0).
//  - Reset during any state aborts the instruction. No write enable survives the RST_N fall.
// CONFIGURATION
//  CTRL_ILLEGAL_HALT_EN defined: ILLEGAL -> S_HALT.
//    S_HALT: illegal=1, every enable 0, load_pc=0. Exit only via RST_N.
//  CTRL_ILLEGAL_HALT_EN undefined: ILLEGAL executes as NOP.
//    EXEC: load_pc=1, pc_next_sel=0, no writes, instr_done=1. 3 cycles; illegal still pulses high.
// STRUCTURE
//  - datapath/control_defs.v holds:
//    `defines for opcode values, class codes (3 bits) and state encodings (3 bits);
//    RF_din_sel encodings.
//  - Sub-module control_decoder: combinational opcode/funct3/funct7 -> class, sub, imm_sel.
//    Its class output is registered in DECODE.
//  - The FSM and output logic stay in control_unit_fsm.
// TESTING
//  - Reset: RST_N=0 mid-EXEC of STORE.
//      -> WE_MEM=0 same cycle; reset_pc=1 for 1 cycle after release; next state FETCH.
//  - ADD then SUB: opcode 0110011, funct7 0x00 then 0x20.
//      -> 4 cycles each; sub=0 then 1; WE_RF=1 only in WB with RF_din_sel=01.
//  - LOAD 0000011.
//      -> 5 cycles; ULA_din2_sel=1 DECODE..WB; WE_RF=1 with RF_din_sel=00 in cycle 5.
//  - STORE 0100011.
//      -> WE_MEM=1 exactly once, in cycle 4; WE_RF never asserted.
//  - BEQ 1100011.
//      -> 3 cycles; sub=1, pc_next_sel=1, load_pc=1 in EXEC.
//  - JALR 1100111.
//      -> pc_adder_sel=1 in EXEC; WB WE_RF=1, RF_din_sel=10.
//  - Opcode 1111111, both macro settings:
//      HALT: illegal stays 1, no load_pc for 20 cycles.
//      NOP: load_pc once, 3 cycles.
//  - Invariants checked throughout: load_pc once per instr_done; WE_RF and WE_MEM never both high.

Source files
------------

// File: rtl/control_unit_fsm_pkg.sv
// control_unit_fsm_pkg
//   Shared definitions for the RV64 multicycle controller: opcode values,
//   RF_din_sel encodings, FSM state and instruction-class enumerations, and a
//   helper that tells which classes feed the immediate into the ULA.
//   Optional build macro (used by control_unit_fsm): CTRL_ILLEGAL_HALT_EN.
package control_unit_fsm_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] RF_SEL_DM   = 2'b00;
    localparam logic [1:0] RF_SEL_ULA  = 2'b01;
    localparam logic [1:0] RF_SEL_LINK = 2'b10;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R       = 3'd0,
        CL_I       = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BRANCH  = 3'd4,
        CL_JAL     = 3'd5,
        CL_JALR    = 3'd6,
        CL_ILLEGAL = 3'd7
    } instr_class_t;

    // Classes whose second ULA operand is the immediate rather than rs2.
    function automatic logic uses_imm(input instr_class_t cls);
        return (cls == CL_I) || (cls == CL_LOAD) || (cls == CL_STORE);
    endfunction

endpackage

// File: rtl/control_unit_fsm_if.sv
// control_unit_fsm_if
//   Bundle between the controller and the datapath.
//   IR fields (datapath -> controller): opcode[6:0], funct3[2:0], funct7[6:0].
//   Controls (controller -> datapath): sub, WE_RF, WE_MEM, RF_din_sel[1:0],
//   ULA_din2_sel, load_pc, reset_pc, pc_next_sel, pc_adder_sel.
//   Status (controller -> outside): instr_done, illegal.
//   Modports: master = controller side, slave = datapath side.
interface control_unit_fsm_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic       sub;
    logic       WE_RF;
    logic       WE_MEM;
    logic [1:0] RF_din_sel;
    logic       ULA_din2_sel;
    logic       load_pc;
    logic       reset_pc;
    logic       pc_next_sel;
    logic       pc_adder_sel;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7,
        output sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
               reset_pc, pc_next_sel, pc_adder_sel, instr_done, illegal
    );

    modport slave (
        output opcode, funct3, funct7,
        input  sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
               reset_pc, pc_next_sel, pc_adder_sel, instr_done, illegal
    );

endinterface

// File: rtl/control_unit_fsm_decoder.sv
// control_unit_fsm_decoder
//   Purely combinational decode of the IR fields into an instruction class
//   and the ULA subtract request.
//   Parameter FUNCT7_CHECK: 1 = R-type with funct7 outside {0x00,0x20} is
//   illegal; 0 = only funct7[5] is looked at.
//   Ports: opcode[6:0], funct3[2:0], funct7[6:0] in; cls, sub out.
module control_unit_fsm_decoder
    import control_unit_fsm_pkg::*;
#(
    parameter int FUNCT7_CHECK = 1
) (
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output instr_class_t cls,
    output logic         sub
);

    always_comb begin
        cls = CL_ILLEGAL;
        sub = 1'b0;
        case (opcode)
            OPC_R: begin
                if ((FUNCT7_CHECK != 0) && (funct7 != 7'h00) && (funct7 != 7'h20)) begin
                    cls = CL_ILLEGAL;
                end else begin
                    cls = CL_R;
                    // Only the ADD/SUB slot (funct3=000) uses funct7[5] as subtract.
                    sub = (funct3 == 3'b000) && funct7[5];
                end
            end
            OPC_I:      cls = CL_I;
            OPC_LOAD:   cls = CL_LOAD;
            OPC_STORE:  cls = CL_STORE;
            OPC_BRANCH: begin
                cls = CL_BRANCH;
                // Branch compares are done as rs1 - rs2 so flags are valid.
                sub = 1'b1;
            end
            OPC_JAL:    cls = CL_JAL;
            OPC_JALR:   cls = CL_JALR;
            default:    cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// control_unit_fsm
//   Multicycle controller for the RV64 datapath. Sequences
//   FETCH/DECODE/EXEC/MEM/WB per instruction class and drives every datapath
//   control as a Moore function of state and the class latched in DECODE.
//   Parameters: RESET_CYCLES (>=1) cycles of reset_pc after RST_N release;
//               FUNCT7_CHECK forwarded to the decoder.
//   Ports: CLK (rising edge), RST_N (async, active-low), bus (master modport
//          of control_unit_fsm_if carrying IR fields in, controls out).
//   Build macro: CTRL_ILLEGAL_HALT_EN -- when defined an illegal instruction
//   parks the FSM in S_HALT until reset; otherwise it runs as a NOP.
module control_unit_fsm
    import control_unit_fsm_pkg::*;
#(
    parameter int RESET_CYCLES = 1,
    parameter int FUNCT7_CHECK = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    control_unit_fsm_if.master  bus
);

    localparam int              CNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

    state_t          state_q, state_d;
    instr_class_t    class_q, class_d;
    logic            sub_q, sub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    instr_class_t    dec_class;
    logic            dec_sub;
    instr_class_t    cur_class;
    logic            cur_sub;

    logic            sub_o, we_rf_o, we_mem_o, ula_din2_sel_o, load_pc_o;
    logic            reset_pc_o, pc_next_sel_o, pc_adder_sel_o, instr_done_o, illegal_o;
    logic [1:0]      rf_din_sel_o;

    control_unit_fsm_decoder #(
        .FUNCT7_CHECK(FUNCT7_CHECK)
    ) u_decoder (
        .opcode (bus.opcode),
        .funct3 (bus.funct3),
        .funct7 (bus.funct7),
        .cls    (dec_class),
        .sub    (dec_sub)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_RESET;
            class_q <= CL_R;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        class_d        = class_q;
        sub_d          = sub_q;
        cnt_d          = cnt_q;
        sub_o          = 1'b0;
        we_rf_o        = 1'b0;
        we_mem_o       = 1'b0;
        rf_din_sel_o   = RF_SEL_DM;
        ula_din2_sel_o = 1'b0;
        load_pc_o      = 1'b0;
        reset_pc_o     = 1'b0;
        pc_next_sel_o  = 1'b0;
        pc_adder_sel_o = 1'b0;
        instr_done_o   = 1'b0;
        illegal_o      = 1'b0;

        // The class register only loads at the end of DECODE, so DECODE
        // itself looks straight at the decoder (IR is already stable).
        cur_class = (state_q == S_DECODE) ? dec_class : class_q;
        cur_sub   = (state_q == S_DECODE) ? dec_sub   : sub_q;

        if ((state_q == S_DECODE) || (state_q == S_EXEC) ||
            (state_q == S_MEM)    || (state_q == S_WB)) begin
            ula_din2_sel_o = uses_imm(cur_class);
            sub_o          = cur_sub;
            illegal_o      = (cur_class == CL_ILLEGAL);
        end

        case (state_q)
            S_RESET: begin
                reset_pc_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
                class_d = dec_class;
                sub_d   = dec_sub;
`ifdef CTRL_ILLEGAL_HALT_EN
                state_d = (dec_class == CL_ILLEGAL) ? S_HALT : S_EXEC;
`else
                state_d = S_EXEC;
`endif
            end

            S_EXEC: begin
                case (class_q)
                    CL_R, CL_I: state_d = S_WB;
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    CL_BRANCH: begin
                        // Taken/not-taken is resolved by the PC unit from flags.
                        load_pc_o     = 1'b1;
                        pc_next_sel_o = 1'b1;
                        instr_done_o  = 1'b1;
                        state_d       = S_FETCH;
                    end
                    CL_JAL, CL_JALR: begin
                        // PC moves now; last_pc keeps the link for WB.
                        load_pc_o      = 1'b1;
                        pc_next_sel_o  = 1'b1;
                        pc_adder_sel_o = (class_q == CL_JALR);
                        state_d        = S_WB;
                    end
                    default: begin
                        // Illegal instruction retires as a NOP.
                        load_pc_o    = 1'b1;
                        instr_done_o = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                if (class_q == CL_STORE) begin
                    we_mem_o     = 1'b1;
                    load_pc_o    = 1'b1;
                    instr_done_o = 1'b1;
                    state_d      = S_FETCH;
                end else if (class_q == CL_LOAD) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_WB: begin
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
                case (class_q)
                    CL_R, CL_I: begin
                        we_rf_o      = 1'b1;
                        rf_din_sel_o = RF_SEL_ULA;
                        load_pc_o    = 1'b1;
                    end
                    CL_LOAD: begin
                        we_rf_o      = 1'b1;
                        rf_din_sel_o = RF_SEL_DM;
                        load_pc_o    = 1'b1;
                    end
                    CL_JAL, CL_JALR: begin
                        // PC already advanced in EXEC; only write the link.
                        we_rf_o      = 1'b1;
                        rf_din_sel_o = RF_SEL_LINK;
                    end
                    default: ;
                endcase
            end

            S_HALT: illegal_o = 1'b1;

            default: state_d = S_FETCH;
        endcase
    end

    assign bus.sub          = sub_o;
    assign bus.WE_RF        = we_rf_o;
    assign bus.WE_MEM       = we_mem_o;
    assign bus.RF_din_sel   = rf_din_sel_o;
    assign bus.ULA_din2_sel = ula_din2_sel_o;
    assign bus.load_pc      = load_pc_o;
    assign bus.reset_pc     = reset_pc_o;
    assign bus.pc_next_sel  = pc_next_sel_o;
    assign bus.pc_adder_sel = pc_adder_sel_o;
    assign bus.instr_done   = instr_done_o;
    assign bus.illegal      = illegal_o;

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm
//   Directed bench for control_unit_fsm. Each instruction pushes its expected
//   per-cycle control vectors into a scoreboard queue; the vectors are popped
//   and compared at every falling clock edge. Honors CTRL_ILLEGAL_HALT_EN.
module tb_control_unit_fsm;

    typedef struct packed {
        logic       sub;
        logic       we_rf;
        logic       we_mem;
        logic [1:0] rf_sel;
        logic       ula_sel;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_next_sel;
        logic       pc_adder_sel;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    logic CLK;
    logic RST_N;

    control_unit_fsm_if bus();

    control_unit_fsm #(
        .RESET_CYCLES(1),
        .FUNCT7_CHECK(1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    ctrl_t expQ[$];
    string tagQ[$];
    int    assertCount = 0;
    int    failCount   = 0;
    int    loadPcCount = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic ctrl_t observed();
        ctrl_t o;
        o.sub          = bus.sub;
        o.we_rf        = bus.WE_RF;
        o.we_mem       = bus.WE_MEM;
        o.rf_sel       = bus.RF_din_sel;
        o.ula_sel      = bus.ULA_din2_sel;
        o.load_pc      = bus.load_pc;
        o.reset_pc     = bus.reset_pc;
        o.pc_next_sel  = bus.pc_next_sel;
        o.pc_adder_sel = bus.pc_adder_sel;
        o.instr_done   = bus.instr_done;
        o.illegal      = bus.illegal;
        return o;
    endfunction

    function automatic void pushCycle(input ctrl_t v, input string tag);
        expQ.push_back(v);
        tagQ.push_back(tag);
    endfunction

    function automatic void checkVec(input ctrl_t exp, input string tag);
        ctrl_t obs;
        obs = observed();
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endfunction

    // Drive IR fields and push the expected cycle-by-cycle controls.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input string name);
        ctrl_t zero, base, v;
        bit    isR, isI, isLoad, isStore, isBranch, isJal, isJalr, legalR, bad;
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        isR      = (op == 7'b0110011);
        isI      = (op == 7'b0010011);
        isLoad   = (op == 7'b0000011);
        isStore  = (op == 7'b0100011);
        isBranch = (op == 7'b1100011);
        isJal    = (op == 7'b1101111);
        isJalr   = (op == 7'b1100111);
        legalR   = (f7 == 7'h00) || (f7 == 7'h20);
        bad      = !((isR && legalR) || isI || isLoad || isStore || isBranch || isJal || isJalr);
        zero         = '0;
        base         = '0;
        base.sub     = (isR && legalR && (f3 == 3'b000) && f7[5]) || isBranch;
        base.ula_sel = isI || isLoad || isStore;
        base.illegal = bad;
        pushCycle(zero, {name, ".FETCH"});
        pushCycle(base, {name, ".DECODE"});
        if (bad) begin
`ifdef CTRL_ILLEGAL_HALT_EN
            for (int i = 0; i < 20; i++) begin
                v = '0; v.illegal = 1'b1;
                pushCycle(v, {name, ".HALT"});
            end
`else
            v = base; v.load_pc = 1'b1; v.instr_done = 1'b1;
            pushCycle(v, {name, ".EXEC"});
`endif
        end else if (isBranch) begin
            v = base; v.load_pc = 1'b1; v.pc_next_sel = 1'b1; v.instr_done = 1'b1;
            pushCycle(v, {name, ".EXEC"});
        end else if (isJal || isJalr) begin
            v = base; v.load_pc = 1'b1; v.pc_next_sel = 1'b1; v.pc_adder_sel = isJalr;
            pushCycle(v, {name, ".EXEC"});
            v = base; v.we_rf = 1'b1; v.rf_sel = 2'b10; v.instr_done = 1'b1;
            pushCycle(v, {name, ".WB"});
        end else if (isStore) begin
            pushCycle(base, {name, ".EXEC"});
            v = base; v.we_mem = 1'b1; v.load_pc = 1'b1; v.instr_done = 1'b1;
            pushCycle(v, {name, ".MEM"});
        end else if (isLoad) begin
            pushCycle(base, {name, ".EXEC"});
            pushCycle(base, {name, ".MEM"});
            v = base; v.we_rf = 1'b1; v.rf_sel = 2'b00; v.load_pc = 1'b1; v.instr_done = 1'b1;
            pushCycle(v, {name, ".WB"});
        end else begin
            pushCycle(base, {name, ".EXEC"});
            v = base; v.we_rf = 1'b1; v.rf_sel = 2'b01; v.load_pc = 1'b1; v.instr_done = 1'b1;
            pushCycle(v, {name, ".WB"});
        end
    endtask

    // Pop n expected vectors, one per falling edge, plus the invariants.
    task automatic checkOutput(input int n);
        ctrl_t exp, obs;
        string tag;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            checkVec(exp, tag);
            obs = observed();
            assertCount++;
            assert (!(obs.we_rf && obs.we_mem)) else begin
                failCount++;
                $error("[TB] FAIL %s.we_excl: observed WE_RF=%b WE_MEM=%b expected not both 1",
                       tag, obs.we_rf, obs.we_mem);
            end
            if (obs.load_pc) loadPcCount++;
            if (obs.instr_done) begin
                assertCount++;
                assert (loadPcCount === 1) else begin
                    failCount++;
                    $error("[TB] FAIL %s.load_pc_once: observed %0d expected 1", tag, loadPcCount);
                end
                loadPcCount = 0;
            end
        end
    endtask

    // Pull RST_N low just after a falling edge, release just after a rising edge.
    task automatic doReset(input string name);
        ctrl_t rv;
        rv = '0;
        rv.reset_pc = 1'b1;
        #1 RST_N = 1'b0;
        #1 checkVec(rv, {name, ".asserted"});
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        checkVec(rv, {name, ".released"});
        expQ.delete();
        tagQ.delete();
        loadPcCount = 0;
    endtask

    task automatic runIllegal(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input string name);
        applyStimulus(op, f3, f7, name);
`ifdef CTRL_ILLEGAL_HALT_EN
        checkOutput(22);
        doReset({name, ".exit"});
`else
        checkOutput(3);
`endif
    endtask

    initial begin
        ctrl_t rv;
        RST_N      = 1'b1;
        bus.opcode = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'd0;
        #2 RST_N = 1'b0;
        rv = '0;
        rv.reset_pc = 1'b1;
        @(negedge CLK);
        checkVec(rv, "reset.held");
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        checkVec(rv, "reset.released");

        applyStimulus(7'b0110011, 3'b000, 7'h00, "ADD");   checkOutput(4);
        applyStimulus(7'b0110011, 3'b000, 7'h20, "SUB");   checkOutput(4);
        applyStimulus(7'b0000011, 3'b011, 7'h00, "LD");    checkOutput(5);
        applyStimulus(7'b0100011, 3'b011, 7'h00, "SD");    checkOutput(4);
        applyStimulus(7'b1100011, 3'b000, 7'h00, "BEQ");   checkOutput(3);
        applyStimulus(7'b1100111, 3'b000, 7'h00, "JALR");  checkOutput(4);
        applyStimulus(7'b1101111, 3'b101, 7'h20, "JAL");   checkOutput(4);
        applyStimulus(7'b0010011, 3'b000, 7'h20, "ADDI");  checkOutput(4);
        applyStimulus(7'b0110011, 3'b111, 7'h20, "R_F3");  checkOutput(4);

        applyStimulus(7'b0100011, 3'b011, 7'h00, "SD_ABORT_EXEC");
        checkOutput(3);
        doReset("abort_exec");
        applyStimulus(7'b0100011, 3'b011, 7'h00, "SD_ABORT_MEM");
        checkOutput(4);
        doReset("abort_mem");

        runIllegal(7'b1111111, 3'b000, 7'h00, "ILL_OPC");
        runIllegal(7'b0110011, 3'b000, 7'h01, "ILL_F7");

        applyStimulus(7'b0110011, 3'b000, 7'h20, "SUB2");  checkOutput(4);

        $display("[TB] directed sequence complete");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
